stat_bist_harness: RTL

- Parametrised self-test harness for the generated Stat_* combinational benchmarks. It is the sequential successor to the fixed 32-in/32-out netlists.
- An internal LFSR drives the benchmark's primary inputs. A MISR compacts the benchmark's outputs over a programmable number of patterns. The final signature is compared against a golden value.
- Sits between the testbench/locking-evaluation flow and any Stat_* instance. Supports pipelined (registered) benchmark variants through a response-latency parameter.

---
 rtl/stat_bist_harness_if.sv | 30 +++
 rtl/stat_bist_harness.sv | 126 ++++++++++++
 2 files changed

// File: rtl/stat_bist_harness_if.sv
// Bus between the BIST harness and its driver: run control, benchmark pattern/response
// path and run status. clk/rst stay outside as plain ports.
interface stat_bist_harness_if #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 32,
    parameter int PATTERNS = 1024
);
    localparam int CNT_W = $clog2(PATTERNS + 1);

    logic             start_i;
    logic [OUT_W-1:0] golden_i;
    logic [IN_W-1:0]  pattern_o;
    logic             pattern_vld_o;
    logic [OUT_W-1:0] response_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [OUT_W-1:0] signature_o;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  start_i, golden_i, response_i,
        output pattern_o, pattern_vld_o, busy_o, done_o, pass_o, signature_o, count_o
    );

    modport master (
        output start_i, golden_i, response_i,
        input  pattern_o, pattern_vld_o, busy_o, done_o, pass_o, signature_o, count_o
    );
endinterface

// File: rtl/stat_bist_harness.sv
// LFSR-driven self-test harness for Stat_* benchmarks: applies PATTERNS stimuli, compacts
// the LAT-delayed responses into a MISR and compares the final signature to a golden value.
module stat_bist_harness #(
    parameter int               IN_W      = 32,
    parameter int               OUT_W     = 32,
    parameter int               PATTERNS  = 1024,
    parameter int               LAT       = 0,
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(32'h0000_00C5),
    parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(32'h0000_0001),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(32'h0000_00C5)
) (
    input  logic               clk,
    input  logic               rst,
    stat_bist_harness_if.slave bus
);
    localparam int              CNT_W = $clog2(PATTERNS + 1);
    localparam logic [IN_W-1:0] SEED  = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [IN_W-1:0]  last_q, last_d;
    logic [OUT_W-1:0] misr_q, misr_d;
    logic [OUT_W-1:0] golden_q, golden_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       drain_q, drain_d;
    logic             pass_q, pass_d;
    logic             run;
    logic             vld_del;

    assign run = (state_q == S_RUN);

    // Pattern-valid delayed by the benchmark's pipeline depth gates MISR capture.
    generate
        if (LAT > 0) begin : g_lat
            logic [LAT-1:0] vld_pipe_q;
            always_ff @(posedge clk) begin
                if (rst) vld_pipe_q <= '0;
                else     vld_pipe_q <= (vld_pipe_q << 1) | LAT'(run);
            end
            assign vld_del = vld_pipe_q[LAT-1];
        end else begin : g_nolat
            assign vld_del = run;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        last_d   = last_q;
        misr_d   = misr_q;
        golden_d = golden_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        pass_d   = pass_q;
        if (vld_del)
            misr_d = {misr_q[OUT_W-2:0], 1'b0} ^ (misr_q[OUT_W-1] ? MISR_POLY : '0) ^ bus.response_i;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    lfsr_d   = SEED;
                    misr_d   = '0;
                    cnt_d    = '0;
                    golden_d = bus.golden_i;
                    pass_d   = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = {lfsr_q[IN_W-2:0], 1'b0} ^ (lfsr_q[IN_W-1] ? LFSR_POLY : '0);
                last_d = lfsr_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PATTERNS - 1)) begin
                    if (LAT > 0) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = (misr_d == golden_q);
                    end
                end
            end
            S_DRAIN: begin
                // The last in-flight response lands in the final drain cycle.
                if (drain_q == 4'(LAT - 1)) begin
                    state_d = S_DONE;
                    pass_d  = (misr_d == golden_q);
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= '0;
            last_q   <= '0;
            misr_q   <= '0;
            golden_q <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            last_q   <= last_d;
            misr_q   <= misr_d;
            golden_q <= golden_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.pattern_o     = run ? lfsr_q : last_q;
    assign bus.pattern_vld_o = run;
    assign bus.busy_o        = run || (state_q == S_DRAIN);
    assign bus.done_o        = (state_q == S_DONE);
    assign bus.pass_o        = pass_q;
    assign bus.signature_o   = misr_q;
    assign bus.count_o       = cnt_q;
endmodule
